// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: default widths, requester ids and the command word.
// Pure declarations; no logic, no latency, no flow control.
package dmem_pkg;
  localparam int DMEM_DW    = 32;
  localparam int DMEM_AW    = 16;
  localparam int DMEM_DEPTH = 64;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef struct packed {
    logic                we;
    logic [DMEM_AW-1:0]  addr;
    logic [DMEM_DW-1:0]  wdata;
  } cmd_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester A/B req-gnt buses plus the data-memory pins; err lines exist only with DMEM_ARB_BOUNDS_EN.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DW = DMEM_DW,
  parameter int AW = DMEM_AW
) ();
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain, mem_dataout;
`ifdef DMEM_ARB_BOUNDS_EN
  logic          a_err, b_err;
`endif

  modport slave (
`ifdef DMEM_ARB_BOUNDS_EN
    output a_err, b_err,
`endif
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dataout,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output mem_write, mem_addr, mem_datain
  );

  modport master (
`ifdef DMEM_ARB_BOUNDS_EN
    input  a_err, b_err,
`endif
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dataout,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  mem_write, mem_addr, mem_datain
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, on contention the port other than last_i wins.
// Combinational, zero latency; at most one grant bit set.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_A) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin A/B arbiter for the 64x32 data memory: gnt in cycle N, command registered, read data back in N+2.
// One access per cycle total; a loser keeps req held. DMEM_ARB_BOUNDS_EN adds out-of-range err reporting.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int AW    = DMEM_AW,
  parameter int DEPTH = DMEM_DEPTH
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  logic [1:0] gnt;
  cmd_t       win_cmd;
  logic       oob;

  port_id_t      last_q, last_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_datain_q, mem_datain_d;
  logic          issue_vld_q, issue_vld_d;
  port_id_t      issue_owner_q, issue_owner_d;
  logic          issue_rd_q, issue_rd_d;
  logic          issue_oob_q, issue_oob_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DW-1:0] ret_data;

  rr_arb2 u_arb (
    .req_i  ({bus.b_req, bus.a_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign bus.a_gnt = gnt[0];
  assign bus.b_gnt = gnt[1];

  always_comb begin
    win_cmd = gnt[1] ? {bus.b_we, bus.b_addr, bus.b_wdata}
                     : {bus.a_we, bus.a_addr, bus.a_wdata};
    oob = 1'b0;
`ifdef DMEM_ARB_BOUNDS_EN
    oob = (win_cmd.addr >= AW'(DEPTH));
`endif
    last_d        = last_q;
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_datain_d  = mem_datain_q;
    issue_vld_d   = 1'b0;
    issue_owner_d = issue_owner_q;
    issue_rd_d    = 1'b0;
    issue_oob_d   = 1'b0;
    if (|gnt) begin
      last_d        = gnt[1] ? PORT_B : PORT_A;
      mem_write_d   = win_cmd.we & ~oob;
      mem_addr_d    = win_cmd.addr;
      mem_datain_d  = win_cmd.wdata;
      issue_vld_d   = 1'b1;
      issue_owner_d = gnt[1] ? PORT_B : PORT_A;
      issue_rd_d    = ~win_cmd.we;
      issue_oob_d   = oob;
    end
  end

  // Read data is sampled in the access cycle; out-of-range reads return zero.
  always_comb begin
    ret_data   = issue_oob_q ? '0 : bus.mem_dataout;
    a_rvalid_d = issue_vld_q & issue_rd_q & (issue_owner_q == PORT_A);
    b_rvalid_d = issue_vld_q & issue_rd_q & (issue_owner_q == PORT_B);
    a_rdata_d  = a_rvalid_d ? ret_data : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? ret_data : b_rdata_q;
    a_err_d    = issue_vld_q & issue_oob_q & (issue_owner_q == PORT_A);
    b_err_d    = issue_vld_q & issue_oob_q & (issue_owner_q == PORT_B);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q        <= PORT_B;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_datain_q  <= '0;
      issue_vld_q   <= 1'b0;
      issue_owner_q <= PORT_A;
      issue_rd_q    <= 1'b0;
      issue_oob_q   <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      a_err_q       <= 1'b0;
      b_err_q       <= 1'b0;
    end else begin
      last_q        <= last_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_datain_q  <= mem_datain_d;
      issue_vld_q   <= issue_vld_d;
      issue_owner_q <= issue_owner_d;
      issue_rd_q    <= issue_rd_d;
      issue_oob_q   <= issue_oob_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      a_err_q       <= a_err_d;
      b_err_q       <= b_err_d;
    end
  end

  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_datain = mem_datain_q;
  assign bus.a_rvalid   = a_rvalid_q;
  assign bus.b_rvalid   = b_rvalid_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
`ifdef DMEM_ARB_BOUNDS_EN
  assign bus.a_err      = a_err_q;
  assign bus.b_err      = b_err_q;
`endif
endmodule
